// File: rtl/bus.sv
`default_nettype none
// ============================================================================
// Module : bus
// Fixed-priority multi-host to multi-device bus: windowed address decode and
// one-cycle response routing back to the granted host.
// Rev    : 1.0
// ============================================================================
module bus #(
  parameter int NrDevices    = 1,
  parameter int NrHosts      = 1,
  parameter int DataWidth    = 32,
  parameter int AddressWidth = 32
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,

  input  logic                    host_req_i     [NrHosts],
  output logic                    host_gnt_o     [NrHosts],
  input  logic [AddressWidth-1:0] host_addr_i    [NrHosts],
  input  logic                    host_we_i      [NrHosts],
  input  logic [DataWidth/8-1:0]  host_be_i      [NrHosts],
  input  logic [DataWidth-1:0]    host_wdata_i   [NrHosts],
  output logic                    host_rvalid_o  [NrHosts],
  output logic [DataWidth-1:0]    host_rdata_o   [NrHosts],
  output logic                    host_err_o     [NrHosts],

  output logic                    device_req_o   [NrDevices],
  output logic [AddressWidth-1:0] device_addr_o  [NrDevices],
  output logic                    device_we_o    [NrDevices],
  output logic [DataWidth/8-1:0]  device_be_o    [NrDevices],
  output logic [DataWidth-1:0]    device_wdata_o [NrDevices],
  input  logic                    device_rvalid_i[NrDevices],
  input  logic [DataWidth-1:0]    device_rdata_i [NrDevices],
  input  logic                    device_err_i   [NrDevices],

  input  logic [AddressWidth-1:0] cfg_device_addr_base [NrDevices],
  input  logic [AddressWidth-1:0] cfg_device_addr_mask [NrDevices]
);

  localparam int C_HOST_IDX_W = (NrHosts   > 1) ? $clog2(NrHosts)   : 1;
  localparam int C_DEV_IDX_W  = (NrDevices > 1) ? $clog2(NrDevices) : 1;

  logic                    w_host_req;
  logic [C_HOST_IDX_W-1:0] w_host_sel;
  logic [AddressWidth-1:0] w_host_addr;
  logic                    w_host_we;
  logic [DataWidth/8-1:0]  w_host_be;
  logic [DataWidth-1:0]    w_host_wdata;

  logic                    w_dev_hit;
  logic [C_DEV_IDX_W-1:0]  w_dev_sel;

  logic                    w_rsp_rvalid;
  logic [DataWidth-1:0]    w_rsp_rdata;
  logic                    w_rsp_err;

  logic                    r_pending;
  logic                    r_miss;
  logic [C_HOST_IDX_W-1:0] r_host;
  logic [C_DEV_IDX_W-1:0]  r_dev;

  // Arbitration: scan high-to-low so the lowest requesting index wins.
  always_comb begin
    w_host_req   = 1'b0;
    w_host_sel   = '0;
    w_host_addr  = '0;
    w_host_we    = 1'b0;
    w_host_be    = '0;
    w_host_wdata = '0;
    for (int h = NrHosts - 1; h >= 0; h--) begin
      if (host_req_i[h]) begin
        w_host_req = 1'b1;
        w_host_sel = C_HOST_IDX_W'(h);
      end
    end
    for (int h = 0; h < NrHosts; h++) begin
      host_gnt_o[h] = w_host_req && (w_host_sel == C_HOST_IDX_W'(h));
      if (w_host_sel == C_HOST_IDX_W'(h)) begin
        w_host_addr  = host_addr_i[h];
        w_host_we    = host_we_i[h];
        w_host_be    = host_be_i[h];
        w_host_wdata = host_wdata_i[h];
      end
    end
  end

  // Decode and device-side fan-out; unselected devices see all zeros.
  always_comb begin
    w_dev_hit = 1'b0;
    w_dev_sel = '0;
    for (int d = NrDevices - 1; d >= 0; d--) begin
      if ((w_host_addr & cfg_device_addr_mask[d]) == cfg_device_addr_base[d]) begin
        w_dev_hit = 1'b1;
        w_dev_sel = C_DEV_IDX_W'(d);
      end
    end
    for (int d = 0; d < NrDevices; d++) begin
      device_req_o[d]   = 1'b0;
      device_addr_o[d]  = '0;
      device_we_o[d]    = 1'b0;
      device_be_o[d]    = '0;
      device_wdata_o[d] = '0;
      if (w_host_req && w_dev_hit && (w_dev_sel == C_DEV_IDX_W'(d))) begin
        device_req_o[d]   = 1'b1;
        device_addr_o[d]  = w_host_addr;
        device_we_o[d]    = w_host_we;
        device_be_o[d]    = w_host_be;
        device_wdata_o[d] = w_host_wdata;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_pending <= 1'b0;
      r_miss    <= 1'b0;
      r_host    <= '0;
      r_dev     <= '0;
    end else begin
      r_pending <= w_host_req;
      if (w_host_req) begin
        r_miss <= !w_dev_hit;
        r_host <= w_host_sel;
        r_dev  <= w_dev_sel;
      end
    end
  end

  // Only the device that owns the outstanding request can reach a host.
  always_comb begin
    w_rsp_rvalid = 1'b0;
    w_rsp_rdata  = '0;
    w_rsp_err    = 1'b0;
    if (r_miss) begin
      w_rsp_rvalid = 1'b1;
      w_rsp_err    = 1'b1;
    end else begin
      for (int d = 0; d < NrDevices; d++) begin
        if (r_dev == C_DEV_IDX_W'(d)) begin
          w_rsp_rvalid = device_rvalid_i[d];
          w_rsp_rdata  = device_rdata_i[d];
          w_rsp_err    = device_err_i[d];
        end
      end
    end
    for (int h = 0; h < NrHosts; h++) begin
      host_rvalid_o[h] = 1'b0;
      host_rdata_o[h]  = '0;
      host_err_o[h]    = 1'b0;
      if (r_pending && (r_host == C_HOST_IDX_W'(h))) begin
        host_rvalid_o[h] = w_rsp_rvalid;
        host_rdata_o[h]  = w_rsp_rdata;
        host_err_o[h]    = w_rsp_err;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_bus.sv
`default_nettype none
// ============================================================================
// Module : tb_bus
// Directed bench for bus: single-host decode/response paths, two-host priority
// and reset dropping an outstanding response.
// Rev    : 1.0
// ============================================================================
module tb_bus;
  logic clk = 1'b0;
  logic rst_n;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  logic [31:0] cfg_base [3];
  logic [31:0] cfg_mask [3];

  // Single-host instance
  logic        a_host_req    [1];
  logic        a_host_gnt    [1];
  logic [31:0] a_host_addr   [1];
  logic        a_host_we     [1];
  logic [3:0]  a_host_be     [1];
  logic [31:0] a_host_wdata  [1];
  logic        a_host_rvalid [1];
  logic [31:0] a_host_rdata  [1];
  logic        a_host_err    [1];
  logic        a_dev_req     [3];
  logic [31:0] a_dev_addr    [3];
  logic        a_dev_we      [3];
  logic [3:0]  a_dev_be      [3];
  logic [31:0] a_dev_wdata   [3];
  logic        a_dev_rvalid  [3];
  logic [31:0] a_dev_rdata   [3];
  logic        a_dev_err     [3];

  // Two-host instance
  logic        b_host_req    [2];
  logic        b_host_gnt    [2];
  logic [31:0] b_host_addr   [2];
  logic        b_host_we     [2];
  logic [3:0]  b_host_be     [2];
  logic [31:0] b_host_wdata  [2];
  logic        b_host_rvalid [2];
  logic [31:0] b_host_rdata  [2];
  logic        b_host_err    [2];
  logic        b_dev_req     [3];
  logic [31:0] b_dev_addr    [3];
  logic        b_dev_we      [3];
  logic [3:0]  b_dev_be      [3];
  logic [31:0] b_dev_wdata   [3];
  logic        b_dev_rvalid  [3];
  logic [31:0] b_dev_rdata   [3];
  logic        b_dev_err     [3];

  bus #(.NrDevices(3), .NrHosts(1), .DataWidth(32), .AddressWidth(32)) u_dut_a (
    .clk_i               (clk),
    .rst_ni              (rst_n),
    .host_req_i          (a_host_req),
    .host_gnt_o          (a_host_gnt),
    .host_addr_i         (a_host_addr),
    .host_we_i           (a_host_we),
    .host_be_i           (a_host_be),
    .host_wdata_i        (a_host_wdata),
    .host_rvalid_o       (a_host_rvalid),
    .host_rdata_o        (a_host_rdata),
    .host_err_o          (a_host_err),
    .device_req_o        (a_dev_req),
    .device_addr_o       (a_dev_addr),
    .device_we_o         (a_dev_we),
    .device_be_o         (a_dev_be),
    .device_wdata_o      (a_dev_wdata),
    .device_rvalid_i     (a_dev_rvalid),
    .device_rdata_i      (a_dev_rdata),
    .device_err_i        (a_dev_err),
    .cfg_device_addr_base(cfg_base),
    .cfg_device_addr_mask(cfg_mask)
  );

  bus #(.NrDevices(3), .NrHosts(2), .DataWidth(32), .AddressWidth(32)) u_dut_b (
    .clk_i               (clk),
    .rst_ni              (rst_n),
    .host_req_i          (b_host_req),
    .host_gnt_o          (b_host_gnt),
    .host_addr_i         (b_host_addr),
    .host_we_i           (b_host_we),
    .host_be_i           (b_host_be),
    .host_wdata_i        (b_host_wdata),
    .host_rvalid_o       (b_host_rvalid),
    .host_rdata_o        (b_host_rdata),
    .host_err_o          (b_host_err),
    .device_req_o        (b_dev_req),
    .device_addr_o       (b_dev_addr),
    .device_we_o         (b_dev_we),
    .device_be_o         (b_dev_be),
    .device_wdata_o      (b_dev_wdata),
    .device_rvalid_i     (b_dev_rvalid),
    .device_rdata_i      (b_dev_rdata),
    .device_err_i        (b_dev_err),
    .cfg_device_addr_base(cfg_base),
    .cfg_device_addr_mask(cfg_mask)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    a_host_req[0] = 1'b0; a_host_addr[0] = '0; a_host_we[0] = 1'b0;
    a_host_be[0]  = '0;   a_host_wdata[0] = '0;
    for (int h = 0; h < 2; h++) begin
      b_host_req[h] = 1'b0; b_host_addr[h] = '0; b_host_we[h] = 1'b0;
      b_host_be[h]  = '0;   b_host_wdata[h] = '0;
    end
    for (int d = 0; d < 3; d++) begin
      a_dev_rvalid[d] = 1'b0; a_dev_rdata[d] = '0; a_dev_err[d] = 1'b0;
      b_dev_rvalid[d] = 1'b0; b_dev_rdata[d] = '0; b_dev_err[d] = 1'b0;
    end
  endtask

  task automatic a_req(input logic [31:0] addr, input logic we, input logic [31:0] wdata);
    a_host_req[0] = 1'b1; a_host_addr[0] = addr; a_host_we[0] = we;
    a_host_be[0]  = 4'hF; a_host_wdata[0] = wdata;
  endtask

  task automatic a_rsp(input int d, input logic [31:0] rdata, input logic err);
    a_dev_rvalid[d] = 1'b1; a_dev_rdata[d] = rdata; a_dev_err[d] = err;
  endtask

  task automatic b_req(input int h, input logic [31:0] addr);
    b_host_req[h] = 1'b1; b_host_addr[h] = addr; b_host_we[h] = 1'b0;
    b_host_be[h]  = 4'hF; b_host_wdata[h] = '0;
  endtask

  task automatic b_rsp(input int d, input logic [31:0] rdata, input logic err);
    b_dev_rvalid[d] = 1'b1; b_dev_rdata[d] = rdata; b_dev_err[d] = err;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0;
    cfg_base[0] = 32'h0010_0000; cfg_mask[0] = 32'hFFF0_0000;
    cfg_base[1] = 32'h0002_0000; cfg_mask[1] = 32'hFFFF_FC00;
    cfg_base[2] = 32'h0003_0000; cfg_mask[2] = 32'hFFFF_FC00;
    idle();

    // In reset: request path stays live, response path stays quiet.
    tick(); a_req(32'h0010_0010, 1'b0, '0); #1;
    check("rst_rvalid",   a_host_rvalid[0], 0);
    check("rst_err",      a_host_err[0],    0);
    check("rst_gnt",      a_host_gnt[0],    1);
    check("rst_dev0_req", a_dev_req[0],     1);
    tick();
    check("rst_rvalid_after_edge", a_host_rvalid[0], 0);
    idle(); rst_n = 1'b1;

    // Read to dev0
    tick(); idle(); a_req(32'h0010_0010, 1'b0, '0); #1;
    check("idle_rvalid",   a_host_rvalid[0], 0);
    check("idle_rdata",    a_host_rdata[0],  0);
    check("rd_gnt",        a_host_gnt[0],    1);
    check("rd_dev0_req",   a_dev_req[0],     1);
    check("rd_dev0_addr",  a_dev_addr[0],    32'h0010_0010);
    check("rd_dev0_we",    a_dev_we[0],      0);
    check("rd_dev1_req",   a_dev_req[1],     0);
    check("rd_dev2_req",   a_dev_req[2],     0);
    check("rd_dev1_addr",  a_dev_addr[1],    0);

    // dev0 responds while a write to dev1 issues back-to-back
    tick(); idle(); a_rsp(0, 32'hDEAD_BEEF, 1'b0); a_req(32'h0002_0000, 1'b1, 32'h41); #1;
    check("rd_rvalid",     a_host_rvalid[0], 1);
    check("rd_rdata",      a_host_rdata[0],  32'hDEAD_BEEF);
    check("rd_err",        a_host_err[0],    0);
    check("wr_gnt",        a_host_gnt[0],    1);
    check("wr_dev1_req",   a_dev_req[1],     1);
    check("wr_dev1_we",    a_dev_we[1],      1);
    check("wr_dev1_wdata", a_dev_wdata[1],   32'h41);
    check("wr_dev1_be",    a_dev_be[1],      4'hF);
    check("wr_dev0_req",   a_dev_req[0],     0);
    check("wr_dev2_req",   a_dev_req[2],     0);
    check("wr_dev0_wdata", a_dev_wdata[0],   0);

    // dev1 responds; stray dev0 response must be ignored
    tick(); idle(); a_rsp(1, 32'h5555_AAAA, 1'b0); a_rsp(0, 32'h1234_5678, 1'b0);
    a_req(32'h0003_0004, 1'b0, '0); #1;
    check("wr_rvalid",     a_host_rvalid[0], 1);
    check("wr_rdata",      a_host_rdata[0],  32'h5555_AAAA);
    check("wr_err",        a_host_err[0],    0);
    check("e_dev2_req",    a_dev_req[2],     1);
    check("e_dev2_addr",   a_dev_addr[2],    32'h0003_0004);
    check("e_dev1_req",    a_dev_req[1],     0);

    // dev2 error response; unmapped address issued next
    tick(); idle(); a_rsp(2, 32'h0, 1'b1); a_req(32'h0004_0000, 1'b0, '0); #1;
    check("e_rvalid",      a_host_rvalid[0], 1);
    check("e_err",         a_host_err[0],    1);
    check("miss_gnt",      a_host_gnt[0],    1);
    check("miss_dev0_req", a_dev_req[0],     0);
    check("miss_dev1_req", a_dev_req[1],     0);
    check("miss_dev2_req", a_dev_req[2],     0);

    // Decode-miss response, with a stray dev0 rvalid present
    tick(); idle(); a_rsp(0, 32'h77, 1'b0); #1;
    check("miss_rvalid",   a_host_rvalid[0], 1);
    check("miss_err",      a_host_err[0],    1);
    check("miss_rdata",    a_host_rdata[0],  0);

    // Nothing pending: device chatter must not reach the host
    tick(); idle(); a_rsp(1, 32'hABCD, 1'b1); #1;
    check("quiet_rvalid",  a_host_rvalid[0], 0);
    check("quiet_err",     a_host_err[0],    0);
    check("quiet_rdata",   a_host_rdata[0],  0);

    // Two hosts contend: host0 wins
    tick(); idle(); b_req(0, 32'h0010_0010); b_req(1, 32'h0002_0000); #1;
    check("pri_gnt0",      b_host_gnt[0],    1);
    check("pri_gnt1",      b_host_gnt[1],    0);
    check("pri_dev0_req",  b_dev_req[0],     1);
    check("pri_dev1_req",  b_dev_req[1],     0);
    check("pri_dev0_addr", b_dev_addr[0],    32'h0010_0010);

    tick(); idle(); b_rsp(0, 32'hCAFE_F00D, 1'b0); b_req(1, 32'h0002_0000); #1;
    check("pri_h0_rvalid", b_host_rvalid[0], 1);
    check("pri_h0_rdata",  b_host_rdata[0],  32'hCAFE_F00D);
    check("pri_h1_rvalid", b_host_rvalid[1], 0);
    check("pri_h1_rdata",  b_host_rdata[1],  0);
    check("h1_gnt1",       b_host_gnt[1],    1);
    check("h1_gnt0",       b_host_gnt[0],    0);
    check("h1_dev1_req",   b_dev_req[1],     1);

    tick(); idle(); b_rsp(1, 32'h1357_9BDF, 1'b0); b_req(0, 32'h0010_0010); #1;
    check("h1_rvalid",     b_host_rvalid[1], 1);
    check("h1_rdata",      b_host_rdata[1],  32'h1357_9BDF);
    check("h1_h0_rvalid",  b_host_rvalid[0], 0);

    // Host0 was granted just above; reset now must drop its response
    tick(); idle(); #1; rst_n = 1'b0; b_rsp(0, 32'hFFFF, 1'b0); #1;
    check("rstg_h0_rvalid_in_rst", b_host_rvalid[0], 0);
    check("rstg_h0_err_in_rst",    b_host_err[0],    0);
    tick(); rst_n = 1'b1; #1;
    check("rstg_h0_rvalid_release", b_host_rvalid[0], 0);
    tick();
    check("rstg_h0_rvalid_after",   b_host_rvalid[0], 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/bus.md
BUS -- requirements
Module: bus

Interface
REQ-001 SHALL have parameter NrDevices, default 1: number of device (slave) ports.
REQ-002 SHALL have parameter NrHosts, default 1: number of host (master) ports.
REQ-003 SHALL have parameter DataWidth, default 32: data bus width.
REQ-004 SHALL have parameter AddressWidth, default 32: address bus width.
REQ-005 SHALL have port clk_i, input, 1: single clock, rising edge.
REQ-006 SHALL have port rst_ni, input, 1: reset, asynchronous and active-low.
REQ-007 SHALL have host-side inputs (unpacked [NrHosts]): host_req_i 1, host_addr_i AddressWidth, host_we_i 1, host_be_i DataWidth/8, host_wdata_i DataWidth.
REQ-008 SHALL have host-side outputs (unpacked [NrHosts]): host_gnt_o 1, host_rvalid_o 1, host_rdata_o DataWidth, host_err_o 1.
REQ-009 SHALL have device-side outputs (unpacked [NrDevices]): device_req_o 1, device_addr_o AddressWidth, device_we_o 1, device_be_o DataWidth/8, device_wdata_o DataWidth.
REQ-010 SHALL have device-side inputs (unpacked [NrDevices]): device_rvalid_i 1, device_rdata_i DataWidth, device_err_i 1.
REQ-011 SHALL have inputs cfg_device_addr_base and cfg_device_addr_mask, unpacked [NrDevices], AddressWidth each: per-device address window.

Function
REQ-012 Arbitration SHALL be combinational fixed priority: the lowest-index host with host_req_i=1 wins.
REQ-013 Only the winning host SHALL see host_gnt_o=1, in the same cycle as its request; all other hosts SHALL see 0.
REQ-014 Decode SHALL select device d when (host_addr & cfg_device_addr_mask[d]) == cfg_device_addr_base[d]; if several devices match, the lowest index SHALL win.
REQ-015 The selected device SHALL get device_req_o=1 combinationally, with addr/we/be/wdata copied from the winning host.
REQ-016 Non-selected devices SHALL drive device_req_o=0 and all other device outputs 0.
REQ-017 An address matching no device SHALL still be granted and SHALL issue no device request.
REQ-018 On every granted request, the bus SHALL register the host index, the device index, a decode-miss flag and a pending flag.
REQ-019 Devices SHALL respond exactly one cycle after the request; the bus SHALL support back-to-back requests, one per cycle.
REQ-020 In the cycle after a grant, the registered host SHALL receive device_rvalid_i, device_rdata_i and device_err_i from the registered device.
REQ-021 For a decode miss, the host SHALL receive host_rvalid_o=1, host_err_o=1 and host_rdata_o=0 one cycle after the grant.
REQ-022 Hosts with no pending response SHALL see host_rvalid_o=0, host_err_o=0 and host_rdata_o=0.
REQ-023 device_rvalid_i from a device with no pending request SHALL be ignored.
REQ-024 Writes SHALL follow the same response path as reads; host_rdata_o is don't-care for writes but SHALL still be routed.

Reset
REQ-025 rst_ni low SHALL asynchronously clear the pending flag, the decode-miss flag and the registered host/device indices to 0.
REQ-026 During reset, host_rvalid_o and host_err_o SHALL be 0; gnt and device_req SHALL still follow the combinational request path.
REQ-027 A request granted in the cycle before reset asserts SHALL produce no host_rvalid_o after reset releases.

Structure
REQ-028 No shared package SHALL be required; index widths SHALL be local parameters computed with $clog2, with a minimum of 1.
REQ-029 A single flat module SHALL be used with no sub-modules; arbitration and decode SHALL be always_comb blocks and response tracking SHALL be one always_ff block.

Verification
REQ-030 The bench SHALL use NrHosts=1, NrDevices=3 with these windows: dev0 base 0x00100000 mask 0xFFF00000; dev1 base 0x00020000 mask 0xFFFFFC00; dev2 base 0x00030000 mask 0xFFFFFC00.
REQ-031 Read 0x00100010: host0 gnt=1 and dev0 req=1 with addr 0x00100010 in the same cycle; dev0 returns rdata 0xDEADBEEF next cycle -> host rvalid=1, rdata=0xDEADBEEF, err=0.
REQ-032 Write 0x00020000, wdata 0x41, be 0xF: dev1 req=1, we=1, wdata 0x41; dev0 and dev2 req=0; host rvalid=1 next cycle.
REQ-033 Access 0x00030004 with dev2 returning err=1: host sees rvalid=1 and err=1 one cycle later.
REQ-034 Access 0x00040000: no device_req asserted; host gnt=1, then rvalid=1, err=1, rdata=0.
REQ-035 With NrHosts=2, both hosts request simultaneously: host0 gnt=1 and host1 gnt=0, and the response goes only to host0; a grant followed by rst_ni low yields no rvalid after release.
